// File: rtl/pd_pl_pkg.sv
// Shared USB-PD protocol-layer definitions: packet types, message size
// limit, transmit FSM state encoding and a packet-type classifier.
package pd_pl_pkg;

  // Packet types presented to the PHY
  localparam logic [2:0] PKT_SOP         = 3'd0;
  localparam logic [2:0] PKT_SOP_P       = 3'd1;
  localparam logic [2:0] PKT_SOP_PP      = 3'd2;
  localparam logic [2:0] PKT_SOP_P_DBG   = 3'd3;
  localparam logic [2:0] PKT_SOP_PP_DBG  = 3'd4;
  localparam logic [2:0] PKT_HARD_RESET  = 3'd5;
  localparam logic [2:0] PKT_CABLE_RESET = 3'd6;
  localparam logic [2:0] PKT_BIST        = 3'd7;

  // Largest message: 2-byte header plus seven 4-byte data objects
  localparam int PD_MAX_MSG_BYTES = 30;

  // Transmit FSM state encoding
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_FINISH    = 2'd3;

  // SOP-family packets carry a payload; reset/BIST ordered sets do not
  function automatic logic is_sop_family(input logic [2:0] pkt_type);
    return (pkt_type <= PKT_SOP_PP_DBG);
  endfunction

endpackage

// File: rtl/pl_tx_msg_buf.sv
// Message byte buffer: RAM written sequentially at the current count,
// count register with clear, and an asynchronous read port.
module pl_tx_msg_buf
  import pd_pl_pkg::*;
#(
  parameter int BUF_DEPTH = 32,
  parameter int CNT_W     = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_data,
  input  logic                         clr,
  input  logic [$clog2(BUF_DEPTH)-1:0] rd_idx,
  output logic [7:0]                   rd_data,
  output logic [CNT_W-1:0]             cnt
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [7:0]       mem_r [BUF_DEPTH];
  logic [CNT_W-1:0] cnt_r;

  // Byte count: clear has priority over an accepted write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (wr_en) begin
      cnt_r <= cnt_r + ONE_CNT;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Byte storage: each accepted write lands at the next free slot
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[cnt_r[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_idx];
  assign cnt     = cnt_r;

endmodule

// File: rtl/pl_tx_msg_sender.sv
// Protocol-layer transmit stage: buffers one PD message, requests a packet
// from the PHY, streams the payload bytes and reports the PHY result.
// Optional macro PL_TX_AUTO_RETRY_EN: resend failed SOP-family packets up
// to twice and expose msg_tx_retry_cnt.
module pl_tx_msg_sender
  import pd_pl_pkg::*;
#(
  parameter int BUF_DEPTH = 32,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             msg_wr_en,
  input  logic [7:0]       msg_wr_data,
  input  logic             msg_clr,
  output logic [CNT_W-1:0] msg_byte_cnt,
  output logic             msg_full,
  output logic             msg_wr_err,
  input  logic             msg_tx_req,
  input  logic [2:0]       msg_tx_type,
  output logic             msg_tx_busy,
  output logic             msg_tx_done,
  output logic             msg_tx_result,
  output logic             pl2phy_tx_packet_en,
  output logic [2:0]       pl2phy_tx_packet_type,
  input  logic             phy2pl_tx_packet_done,
  input  logic             phy2pl_tx_packet_result,
  output logic             pl2phy_tx_payload_en,
  output logic [7:0]       pl2phy_tx_payload,
  output logic             pl2phy_tx_payload_last,
  input  logic             phy2pl_tx_payload_done
`ifdef PL_TX_AUTO_RETRY_EN
  ,
  output logic [1:0]       msg_tx_retry_cnt
`endif
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] rd_idx_r;
  logic [2:0]       type_r;
  logic             result_r;
  logic             done_r;
  logic             wr_err_r;
  logic             packet_en_r;
  logic             payload_en_r;

  logic [CNT_W-1:0] cnt_s;
  logic [7:0]       rd_data_s;
  logic             idle_s;
  logic             full_s;
  logic             wr_accept_s;
  logic             wr_drop_s;
  logic             buf_clr_s;
  logic             last_s;
  logic             retry_pend_s;

`ifdef PL_TX_AUTO_RETRY_EN
  logic [1:0]       retry_cnt_r;
  logic             retry_pend_r;
  logic             retry_s;

  // A failed SOP-family attempt is resent while retries remain
  assign retry_s      = !phy2pl_tx_packet_result && is_sop_family(type_r) &&
                        (retry_cnt_r != 2'd2);
  assign retry_pend_s = retry_pend_r;
  assign msg_tx_retry_cnt = retry_cnt_r;
`else
  assign retry_pend_s = 1'b0;
`endif

  assign idle_s      = (state_r == ST_IDLE);
  assign full_s      = (cnt_s == DEPTH_CNT);
  // msg_clr in IDLE swallows a same-cycle write without flagging an error
  assign wr_accept_s = idle_s && msg_wr_en && !msg_clr && !msg_tx_req && !full_s;
  assign wr_drop_s   = msg_wr_en && !(idle_s && msg_clr) && !wr_accept_s;
  assign last_s      = payload_en_r && ((rd_idx_r + ONE_CNT) == cnt_s);

  // Buffer is emptied by an explicit clear or by a final successful send
  always_comb begin
    buf_clr_s = 1'b0;
    if (idle_s && msg_clr) begin
      buf_clr_s = 1'b1;
    end else if ((state_r == ST_FINISH) && result_r && !retry_pend_s) begin
      buf_clr_s = 1'b1;
    end else begin
      buf_clr_s = 1'b0;
    end
  end

  pl_tx_msg_buf #(
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_W     (CNT_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_accept_s),
    .wr_data (msg_wr_data),
    .clr     (buf_clr_s),
    .rd_idx  (rd_idx_r[AW-1:0]),
    .rd_data (rd_data_s),
    .cnt     (cnt_s)
  );

  // Transmit FSM with its registered PHY and engine handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rd_idx_r     <= {CNT_W{1'b0}};
      type_r       <= 3'd0;
      result_r     <= 1'b0;
      done_r       <= 1'b0;
      wr_err_r     <= 1'b0;
      packet_en_r  <= 1'b0;
      payload_en_r <= 1'b0;
`ifdef PL_TX_AUTO_RETRY_EN
      retry_cnt_r  <= 2'd0;
      retry_pend_r <= 1'b0;
`endif
    end else begin
      done_r   <= 1'b0;
      wr_err_r <= wr_drop_s;
      case (state_r)
        ST_IDLE: begin
          if (msg_tx_req && !msg_clr) begin
            type_r   <= msg_tx_type;
            rd_idx_r <= {CNT_W{1'b0}};
`ifdef PL_TX_AUTO_RETRY_EN
            retry_cnt_r  <= 2'd0;
            retry_pend_r <= 1'b0;
`endif
            if (!is_sop_family(msg_tx_type)) begin
              state_r     <= ST_WAIT_DONE;
              packet_en_r <= 1'b1;
            end else if (cnt_s == {CNT_W{1'b0}}) begin
              // Nothing to send: reject without touching the PHY
              state_r  <= ST_FINISH;
              result_r <= 1'b0;
            end else begin
              state_r      <= ST_SEND;
              packet_en_r  <= 1'b1;
              payload_en_r <= 1'b1;
            end
          end
        end
        ST_SEND, ST_WAIT_DONE: begin
          // A packet_done during SEND is a PHY abort and ends the packet too
          if (phy2pl_tx_packet_done) begin
            state_r      <= ST_FINISH;
            packet_en_r  <= 1'b0;
            payload_en_r <= 1'b0;
`ifdef PL_TX_AUTO_RETRY_EN
            if (retry_s) begin
              retry_pend_r <= 1'b1;
            end else begin
              result_r <= phy2pl_tx_packet_result;
            end
`else
            result_r <= phy2pl_tx_packet_result;
`endif
          end else if ((state_r == ST_SEND) && phy2pl_tx_payload_done && payload_en_r) begin
            rd_idx_r <= rd_idx_r + ONE_CNT;
            if (last_s) begin
              state_r      <= ST_WAIT_DONE;
              payload_en_r <= 1'b0;
            end
          end
        end
        ST_FINISH: begin
`ifdef PL_TX_AUTO_RETRY_EN
          if (retry_pend_r) begin
            // packet_en stayed low for this one cycle; restart from byte 0
            state_r      <= ST_SEND;
            packet_en_r  <= 1'b1;
            payload_en_r <= 1'b1;
            rd_idx_r     <= {CNT_W{1'b0}};
            retry_cnt_r  <= retry_cnt_r + 2'd1;
            retry_pend_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end
`else
          state_r <= ST_IDLE;
          done_r  <= 1'b1;
`endif
        end
        default: begin
          state_r      <= ST_IDLE;
          packet_en_r  <= 1'b0;
          payload_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign msg_byte_cnt           = cnt_s;
  assign msg_full               = full_s;
  assign msg_wr_err             = wr_err_r;
  assign msg_tx_busy            = (state_r != ST_IDLE);
  assign msg_tx_done            = done_r;
  assign msg_tx_result          = result_r;
  assign pl2phy_tx_packet_en    = packet_en_r;
  assign pl2phy_tx_packet_type  = packet_en_r ? type_r : 3'd0;
  assign pl2phy_tx_payload_en   = payload_en_r;
  assign pl2phy_tx_payload      = payload_en_r ? rd_data_s : 8'h00;
  assign pl2phy_tx_payload_last = last_s;

endmodule

// File: tb/tb_pl_tx_msg_sender.sv
// Directed bench for pl_tx_msg_sender with a queue-based model of the
// buffered message and a per-cycle monitor of count and payload stream.
module tb_pl_tx_msg_sender;

  localparam int BUF_DEPTH = 32;
  localparam int CNT_W     = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             msg_wr_en = 1'b0;
  logic [7:0]       msg_wr_data = 8'h00;
  logic             msg_clr = 1'b0;
  logic [CNT_W-1:0] msg_byte_cnt;
  logic             msg_full;
  logic             msg_wr_err;
  logic             msg_tx_req = 1'b0;
  logic [2:0]       msg_tx_type = 3'd0;
  logic             msg_tx_busy;
  logic             msg_tx_done;
  logic             msg_tx_result;
  logic             pl2phy_tx_packet_en;
  logic [2:0]       pl2phy_tx_packet_type;
  logic             phy2pl_tx_packet_done = 1'b0;
  logic             phy2pl_tx_packet_result = 1'b0;
  logic             pl2phy_tx_payload_en;
  logic [7:0]       pl2phy_tx_payload;
  logic             pl2phy_tx_payload_last;
  logic             phy2pl_tx_payload_done = 1'b0;
`ifdef PL_TX_AUTO_RETRY_EN
  logic [1:0]       msg_tx_retry_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model: buffered bytes, current stream position, expected packet type
  logic [7:0] model_q[$];
  logic [7:0] collected[$];
  logic [2:0] exp_type = 3'd0;
  bit         exp_stream = 1'b0;
  int         rd_ptr = 0;
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;

  pl_tx_msg_sender #(.BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .msg_wr_en               (msg_wr_en),
    .msg_wr_data             (msg_wr_data),
    .msg_clr                 (msg_clr),
    .msg_byte_cnt            (msg_byte_cnt),
    .msg_full                (msg_full),
    .msg_wr_err              (msg_wr_err),
    .msg_tx_req              (msg_tx_req),
    .msg_tx_type             (msg_tx_type),
    .msg_tx_busy             (msg_tx_busy),
    .msg_tx_done             (msg_tx_done),
    .msg_tx_result           (msg_tx_result),
    .pl2phy_tx_packet_en     (pl2phy_tx_packet_en),
    .pl2phy_tx_packet_type   (pl2phy_tx_packet_type),
    .phy2pl_tx_packet_done   (phy2pl_tx_packet_done),
    .phy2pl_tx_packet_result (phy2pl_tx_packet_result),
    .pl2phy_tx_payload_en    (pl2phy_tx_payload_en),
    .pl2phy_tx_payload       (pl2phy_tx_payload),
    .pl2phy_tx_payload_last  (pl2phy_tx_payload_last),
    .phy2pl_tx_payload_done  (phy2pl_tx_payload_done)
`ifdef PL_TX_AUTO_RETRY_EN
    ,
    .msg_tx_retry_cnt        (msg_tx_retry_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle monitor: count/full track the model, stream follows buffer order
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("cnt_model", 32'(msg_byte_cnt), 32'(model_q.size()));
      check("full_model", 32'(msg_full), 32'(model_q.size() == BUF_DEPTH));
      if (pl2phy_tx_payload_en) begin
        check("payload_allowed", 32'(exp_stream), 32'd1);
        check("payload_idx_range", 32'(rd_ptr < model_q.size()), 32'd1);
        check("payload_with_pkt", 32'(pl2phy_tx_packet_en), 32'd1);
        if (rd_ptr < model_q.size()) begin
          check("payload_byte", 32'(pl2phy_tx_payload), 32'(model_q[rd_ptr]));
          check("payload_last", 32'(pl2phy_tx_payload_last), 32'(rd_ptr == model_q.size() - 1));
        end
      end else begin
        check("last_without_en", 32'(pl2phy_tx_payload_last), 32'd0);
      end
      if (pl2phy_tx_packet_en) begin
        check("pkt_type", 32'(pl2phy_tx_packet_type), 32'(exp_type));
        check("busy_with_pkt", 32'(msg_tx_busy), 32'd1);
      end
    end
  end

  task automatic wr_byte(input logic [7:0] d, input bit exp_ok);
    msg_wr_en   = 1'b1;
    msg_wr_data = d;
    tick();
    msg_wr_en = 1'b0;
    if (exp_ok) model_q.push_back(d);
    check("wr_err", 32'(msg_wr_err), 32'(!exp_ok));
  endtask

  task automatic req(input logic [2:0] t);
    msg_tx_req  = 1'b1;
    msg_tx_type = t;
    exp_type    = t;
    exp_stream  = (t <= 3'd4);
    rd_ptr      = 0;
    tick();
    msg_tx_req = 1'b0;
  endtask

  // PHY consumes n bytes, each after wait_cyc cycles of presentation
  task automatic ack_bytes(input int n, input int wait_cyc);
    for (int i = 0; i < n; i++) begin
      repeat (wait_cyc) tick();
      collected.push_back(pl2phy_tx_payload);
      phy2pl_tx_payload_done = 1'b1;
      tick();
      phy2pl_tx_payload_done = 1'b0;
      rd_ptr++;
    end
  endtask

  task automatic pkt_done(input logic res);
    phy2pl_tx_packet_done   = 1'b1;
    phy2pl_tx_packet_result = res;
    tick();
    phy2pl_tx_packet_done   = 1'b0;
    phy2pl_tx_packet_result = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({msg_byte_cnt, msg_full, msg_wr_err, msg_tx_busy, msg_tx_done,
                     msg_tx_result, pl2phy_tx_packet_en, pl2phy_tx_packet_type,
                     pl2phy_tx_payload_en, pl2phy_tx_payload, pl2phy_tx_payload_last}),
          32'd0);
`ifdef PL_TX_AUTO_RETRY_EN
    check({name, "_retry"}, 32'(msg_tx_retry_cnt), 32'd0);
`endif
  endtask

  logic [7:0] lit6 [6];

  initial begin
    lit6 = '{8'h41, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // Six-byte SOP message, PHY acks each byte after 3 cycles
    for (int i = 0; i < 6; i++) wr_byte(lit6[i], 1'b1);
    check("count6", 32'(msg_byte_cnt), 32'd6);
    req(3'd0);
    check("sop_pkt_en", 32'(pl2phy_tx_packet_en), 32'd1);
    check("sop_payload_en", 32'(pl2phy_tx_payload_en), 32'd1);
    check("sop_busy", 32'(msg_tx_busy), 32'd1);
    wr_byte(8'h55, 1'b0);
    ack_bytes(6, 3);
    check("payload_en_after_last", 32'(pl2phy_tx_payload_en), 32'd0);
    check("pkt_en_wait", 32'(pl2phy_tx_packet_en), 32'd1);
    check("collected_len", 32'(collected.size()), 32'd6);
    for (int i = 0; i < 6 && i < collected.size(); i++) check("byte_order", 32'(collected[i]), 32'(lit6[i]));
    exp_stream = 1'b0;
    tick();
    pkt_done(1'b1);
    check("sop_done_early", 32'(msg_tx_done), 32'd0);
    check("sop_pkt_en_drop", 32'(pl2phy_tx_packet_en), 32'd0);
    tick();
    model_q.delete();
    check("sop_done", 32'(msg_tx_done), 32'd1);
    check("sop_result", 32'(msg_tx_result), 32'd1);
    check("sop_busy_end", 32'(msg_tx_busy), 32'd0);
    check("sop_count_cleared", 32'(msg_byte_cnt), 32'd0);
    tick();
    check("sop_done_pulse", 32'(msg_tx_done), 32'd0);
    check("sop_result_held", 32'(msg_tx_result), 32'd1);

    // Hard reset with an empty buffer: no payload
    req(3'd5);
    check("hr_pkt_en", 32'(pl2phy_tx_packet_en), 32'd1);
    check("hr_type", 32'(pl2phy_tx_packet_type), 32'd5);
    check("hr_payload_en", 32'(pl2phy_tx_payload_en), 32'd0);
    repeat (4) tick();
    pkt_done(1'b1);
    check("hr_done_early", 32'(msg_tx_done), 32'd0);
    tick();
    check("hr_done", 32'(msg_tx_done), 32'd1);
    check("hr_result", 32'(msg_tx_result), 32'd1);
    tick();

    // SOP request with an empty buffer is rejected without a PHY request
    req(3'd0);
    check("rej_pkt_en", 32'(pl2phy_tx_packet_en), 32'd0);
    check("rej_busy", 32'(msg_tx_busy), 32'd1);
    tick();
    check("rej_done", 32'(msg_tx_done), 32'd1);
    check("rej_result", 32'(msg_tx_result), 32'd0);
    check("rej_pkt_en2", 32'(pl2phy_tx_packet_en), 32'd0);
    tick();

    // Fill to 32, then overflow write
    for (int i = 0; i < BUF_DEPTH; i++) wr_byte(8'(i * 5 + 1), 1'b1);
    check("full_flag", 32'(msg_full), 32'd1);
    check("count32", 32'(msg_byte_cnt), 32'd32);
    wr_byte(8'hEE, 1'b0);
    check("count32_kept", 32'(msg_byte_cnt), 32'd32);
    tick();
    check("wr_err_pulse", 32'(msg_wr_err), 32'd0);

    // Clear beats a simultaneous write and request
    msg_clr = 1'b1; msg_wr_en = 1'b1; msg_wr_data = 8'h77; msg_tx_req = 1'b1; msg_tx_type = 3'd0;
    tick();
    msg_clr = 1'b0; msg_wr_en = 1'b0; msg_tx_req = 1'b0;
    model_q.delete();
    check("clr_count", 32'(msg_byte_cnt), 32'd0);
    check("clr_busy", 32'(msg_tx_busy), 32'd0);
    check("clr_wr_err", 32'(msg_wr_err), 32'd0);
    tick();
    check("clr_no_req", 32'(msg_tx_busy), 32'd0);

    // Four bytes, write colliding with request, PHY abort after two bytes
    for (int i = 0; i < 4; i++) wr_byte(8'(8'h11 * (i + 1)), 1'b1);
    msg_tx_req = 1'b1; msg_tx_type = 3'd1; exp_type = 3'd1; exp_stream = 1'b1; rd_ptr = 0;
    msg_wr_en = 1'b1; msg_wr_data = 8'h99;
    tick();
    msg_tx_req = 1'b0; msg_wr_en = 1'b0;
    check("req_wr_err", 32'(msg_wr_err), 32'd1);
    check("abort_pkt_en", 32'(pl2phy_tx_packet_en), 32'd1);
    ack_bytes(2, 1);
    pkt_done(1'b0);
    check("abort_payload_drop", 32'(pl2phy_tx_payload_en), 32'd0);
    check("abort_pkt_drop", 32'(pl2phy_tx_packet_en), 32'd0);
    check("abort_done_early", 32'(msg_tx_done), 32'd0);
`ifdef PL_TX_AUTO_RETRY_EN
    rd_ptr = 0;
    tick();
    check("retry1_pkt_en", 32'(pl2phy_tx_packet_en), 32'd1);
    check("retry1_cnt", 32'(msg_tx_retry_cnt), 32'd1);
    check("retry1_no_done", 32'(msg_tx_done), 32'd0);
    ack_bytes(4, 1);
    pkt_done(1'b0);
    check("retry2_gap", 32'(pl2phy_tx_packet_en), 32'd0);
    check("retry2_no_done", 32'(msg_tx_done), 32'd0);
    rd_ptr = 0;
    tick();
    check("retry2_pkt_en", 32'(pl2phy_tx_packet_en), 32'd1);
    check("retry2_cnt", 32'(msg_tx_retry_cnt), 32'd2);
    pkt_done(1'b0);
    check("retry3_no_done", 32'(msg_tx_done), 32'd0);
    check("retry3_payload_drop", 32'(pl2phy_tx_payload_en), 32'd0);
    tick();
    check("retry_final_cnt", 32'(msg_tx_retry_cnt), 32'd2);
`else
    tick();
`endif
    check("abort_done", 32'(msg_tx_done), 32'd1);
    check("abort_result", 32'(msg_tx_result), 32'd0);
    check("abort_count4", 32'(msg_byte_cnt), 32'd4);
    tick();
    check("abort_done_pulse", 32'(msg_tx_done), 32'd0);

    // Asynchronous reset in the middle of SEND
    req(3'd0);
    ack_bytes(1, 1);
    check("pre_reset_payload_en", 32'(pl2phy_tx_payload_en), 32'd1);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    model_q.delete();
    exp_stream = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();
    check("post_reset_count", 32'(msg_byte_cnt), 32'd0);
    check("post_reset_busy", 32'(msg_tx_busy), 32'd0);
    check("post_reset_pkt_en", 32'(pl2phy_tx_packet_en), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pl_tx_msg_sender.md
Name: pl_tx_msg_sender

Overview:
- Protocol-layer transmit stage directly upstream of the PHY top.
- Buffers one USB-PD message (header plus data objects, at most 30 bytes) written by the protocol engine.
- Issues the packet request and type to the PHY, then streams bytes on the pl2phy payload handshake.
- Reports the PHY's packet result back to the engine.

Parameters:
- BUF_DEPTH, 32, message buffer depth in bytes; must be a power of two and at least 30.
- CNT_W, 6, width of the byte count; must satisfy 2^CNT_W > BUF_DEPTH.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- msg_wr_en  input  1  write strobe for one message byte.
- msg_wr_data  input  8  message byte, little-endian transmit order.
- msg_clr  input  1  discards buffer contents.
- msg_byte_cnt  output  CNT_W  number of bytes currently buffered.
- msg_full  output  1  high when msg_byte_cnt == BUF_DEPTH.
- msg_wr_err  output  1  one-cycle pulse when a write is dropped.
- msg_tx_req  input  1  one-cycle start request.
- msg_tx_type  input  3  packet type, sampled together with msg_tx_req.
- msg_tx_busy  output  1  high from request accept until done.
- msg_tx_done  output  1  one-cycle completion pulse.
- msg_tx_result  output  1  1 = sent, 0 = discarded or rejected; valid while msg_tx_done is high and held afterwards.
- pl2phy_tx_packet_en  output  1  packet request level.
- pl2phy_tx_packet_type  output  3  packet type presented to the PHY.
- phy2pl_tx_packet_done  input  1  PHY completion pulse.
- phy2pl_tx_packet_result  input  1  PHY result, valid together with phy2pl_tx_packet_done.
- pl2phy_tx_payload_en  output  1  current byte valid.
- pl2phy_tx_payload  output  8  current byte.
- pl2phy_tx_payload_last  output  1  current byte is the final byte.
- phy2pl_tx_payload_done  input  1  PHY has consumed the current byte.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the buffer is empty.
- Buffer writes:
  - Accepted only in IDLE while not full; each accepted write stores to index msg_byte_cnt and increments the count.
  - A write while full, while busy, or in the same cycle as msg_tx_req is dropped and pulses msg_wr_err.
- msg_clr:
  - In IDLE: count goes to 0 next cycle. msg_clr wins over a simultaneous msg_tx_req or msg_wr_en; the request is ignored and msg_wr_err does not pulse.
  - Outside IDLE: ignored.
- FSM states: IDLE, SEND, WAIT_DONE, FINISH.
- IDLE:
  - msg_tx_req with type 0..4 (SOP family) and count 0 is rejected: FINISH with result 0, and no PHY request is made.
  - msg_tx_req with type 0..4 and count > 0 latches the type and goes to SEND. pl2phy_tx_packet_en and the type rise one cycle after the request; rd_idx is 0.
  - msg_tx_req with type 5, 6 or 7 (HARD_RESET, CABLE_RESET, BIST) goes to WAIT_DONE with packet_en high next cycle. No payload is streamed.
- SEND:
  - pl2phy_tx_payload_en = 1 and pl2phy_tx_payload = buf[rd_idx].
  - pl2phy_tx_payload_last = (rd_idx == count-1), combinational from rd_idx.
  - On phy2pl_tx_payload_done: rd_idx increments. If the byte was the last one, go to WAIT_DONE and deassert payload_en the next cycle.
  - A done pulse arriving while payload_en is low is ignored.
- WAIT_DONE: on phy2pl_tx_packet_done, latch the result, drop packet_en next cycle, go to FINISH.
- phy2pl_tx_packet_done during SEND (PHY abort): treated identically to WAIT_DONE; payload_en drops next cycle.
- FINISH:
  - msg_tx_done pulses for one cycle, then the FSM returns to IDLE.
  - On result 1 the buffer is cleared (count 0); on result 0 the buffer is retained for resend.
- msg_tx_busy = (state != IDLE).
- End-to-end latency: request to packet_en is 1 cycle; PHY packet_done to msg_tx_done is 2 cycles.
- rst_n asserted mid-transfer returns everything to reset values immediately. No partial state survives.

Optional Feature:
- Macro: PL_TX_AUTO_RETRY_EN.
- Defined:
  - On PHY result 0 for SOP-family packets, the block re-enters SEND with rd_idx 0. packet_en is re-raised after exactly 1 idle cycle of packet_en low.
  - At most 2 retries, tracked by a 2-bit counter that is cleared on each new request.
  - msg_tx_done is pulsed only after success or after the final failed attempt.
  - Adds output msg_tx_retry_cnt [1:0], holding the number of retries used.
- Undefined: no retry is performed; the port is absent.

Decomposition:
- Shared package pd_pl_pkg:
  - Packet type constants: SOP=0, SOP_P=1, SOP_PP=2, SOP_P_DBG=3, SOP_PP_DBG=4, HARD_RESET=5, CABLE_RESET=6, BIST=7.
  - PD_MAX_MSG_BYTES=30.
  - FSM state encoding.
- One natural sub-module, pl_tx_msg_buf: byte RAM plus count register, with a write port and an asynchronous read port. The FSM stays in the top.

Test Plan:
- Write 6 bytes 0x41,0x10,0xAA,0xBB,0xCC,0xDD; request type 0; PHY acks each byte after 3 cycles, then packet_done with result 1 -> bytes appear in order, last=1 only on 0xDD, msg_tx_done with result 1, count 0.
- Request type 5 with an empty buffer -> packet_en high, payload_en never rises; packet_done with result 1 -> done with result 1.
- Request type 0 with count 0 -> packet_en stays 0, done with result 0 within 2 cycles.
- Fill 32 bytes, then a 33rd write -> msg_full=1, msg_wr_err pulse, count stays 32.
- PHY packet_done with result 0 after byte 2 of 4 -> payload_en low next cycle, done with result 0, count stays 4. With PL_TX_AUTO_RETRY_EN, three failures give retry_cnt=2 and a single done pulse.
- Assert rst_n low during SEND -> all outputs 0 asynchronously; after release, count is 0 and the FSM is in IDLE.
